// File: rtl/conv5_ctrl_pkg.sv
// Shared types and defaults for the 5x5 convolution sequencer.
// Holds the FSM state enum, default parameters and the result tag layout.
package conv5_ctrl_pkg;

    localparam int K_DEF        = 5;
    localparam int PIPE_LAT_DEF = 11;
    localparam int DIM_W_DEF    = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_FIN
    } state_e;

    // Coordinate tag that travels alongside the engine pipeline.
    typedef struct packed {
        logic                 v;
        logic [DIM_W_DEF-1:0] row;
        logic [DIM_W_DEF-1:0] col;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/conv5_tag_pipe.sv
// Enable-gated delay line that mirrors the engine pipeline for result tags.
// Ports: clk, reset (sync clear), shift (advance), din (head), dout (tail).
module conv5_tag_pipe #(
    parameter int PIPE_LAT = 11,
    parameter int TAG_W    = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout
);

    logic [PIPE_LAT-1:0][TAG_W-1:0] line_q;
    logic [PIPE_LAT-1:0][TAG_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (shift) begin
            line_d[0] = din;
            for (int i = 1; i < PIPE_LAT; i++) begin
                line_d[i] = line_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q[PIPE_LAT-1];

endmodule

// File: rtl/conv5_seq_ctrl.sv
// Frame sequencer for the 5x5 systolic convolution engine: filter load,
// row-window image streaming, pipeline drain and output (row,col) tagging.
// Inputs: clk, reset, start, img_w, img_h, mem_ready.
// Outputs: filt_rd_en/filt_idx, img_rd_en/img_row/img_col, memory_turn,
// out_valid/out_row/out_col, busy, done.
// Macro CONV5_SEQ_CTRL_PERF_EN adds stall_cnt and beat_cnt outputs.
// DIM_W must equal the package tag coordinate width (DIM_W_DEF).
module conv5_seq_ctrl
    import conv5_ctrl_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int DIM_W    = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic             mem_ready,
    output logic             filt_rd_en,
    output logic [2:0]       filt_idx,
    output logic             img_rd_en,
    output logic [DIM_W-1:0] img_row,
    output logic [DIM_W-1:0] img_col,
    output logic             memory_turn,
    output logic             out_valid,
    output logic [DIM_W-1:0] out_row,
    output logic [DIM_W-1:0] out_col,
    output logic             busy,
    output logic             done
`ifdef CONV5_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      beat_cnt
`endif
);

    localparam int DRN_W = $clog2(PIPE_LAT);

    state_e             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic [DIM_W-1:0]   row_q, row_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [2:0]         idx_q, idx_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [DIM_W-1:0]   orow_q, orow_d;
    logic [DIM_W-1:0]   ocol_q, ocol_d;

    logic               drain_turn;
    logic               push;
    tag_t               tag_in;
    tag_t               tail;
    logic [TAG_W-1:0]   tail_vec;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        row_d      = row_q;
        col_d      = col_q;
        idx_d      = idx_q;
        drn_d      = drn_q;
        filt_rd_en = 1'b0;
        filt_idx   = '0;
        img_rd_en  = 1'b0;
        img_row    = '0;
        img_col    = '0;
        drain_turn = 1'b0;
        done       = 1'b0;
        push       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    w_d     = img_w;
                    h_d     = img_h;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    drn_d   = '0;
                end
            end
            ST_LOAD: begin
                filt_rd_en = 1'b1;
                filt_idx   = idx_q;
                if (mem_ready) begin
                    if (idx_q == 3'(K - 1)) begin
                        state_d = ST_STREAM;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STREAM: begin
                img_rd_en = 1'b1;
                img_row   = row_q;
                img_col   = col_q;
                if (mem_ready) begin
                    push = 1'b1;
                    if (col_q == w_q - DIM_W'(1)) begin
                        col_d = '0;
                        // Last window row: stop reading, flush pipe.
                        if (row_q == h_q - DIM_W'(K)) begin
                            state_d = ST_DRAIN;
                            drn_d   = '0;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                drain_turn = 1'b1;
                drn_d      = drn_q + DRN_W'(1);
                if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);

    assign memory_turn = ((filt_rd_en | img_rd_en) & mem_ready)
                       | drain_turn;

    // Only image beats carry a live tag; loads and drain push v=0.
    always_comb begin
        tag_in = '0;
        if (push) begin
            tag_in.v   = (col_q >= DIM_W'(K - 1));
            tag_in.row = row_q;
            tag_in.col = col_q - DIM_W'(K - 1);
        end
    end

    conv5_tag_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .TAG_W    (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .shift (memory_turn),
        .din   (tag_in),
        .dout  (tail_vec)
    );

    assign tail      = tag_t'(tail_vec);
    assign out_valid = tail.v & memory_turn;

    // Coordinates only move on a real result; otherwise show the last one.
    assign out_row = out_valid ? tail.row : orow_q;
    assign out_col = out_valid ? tail.col : ocol_q;
    assign orow_d  = out_row;
    assign ocol_d  = out_col;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            drn_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            drn_q   <= drn_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
        end
    end

`ifdef CONV5_SEQ_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] beat_q, beat_d;

    always_comb begin
        stall_d = stall_q;
        beat_d  = beat_q;
        if (state_q == ST_IDLE && start) begin
            stall_d = '0;
            beat_d  = '0;
        end else if (filt_rd_en | img_rd_en) begin
            if (!mem_ready) begin
                if (stall_q != '1) stall_d = stall_q + 32'd1;
            end else begin
                if (beat_q != '1) beat_d = beat_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            beat_q  <= '0;
        end else begin
            stall_q <= stall_d;
            beat_q  <= beat_d;
        end
    end

    assign stall_cnt = stall_q;
    assign beat_cnt  = beat_q;
`endif

endmodule
